ifu_fetch: RTL

- Instruction fetch stage directly upstream of the decode/branch-predict stage.
- Generates sequential PCs and issues word fetches on a req/gnt instruction bus.
- Buffers returned instructions in a small in-order FIFO and presents them as data_vld/iaddr/data to the next stage.
- Handles redirects from the branch predictor and pipeline flush, discarding stale in-flight responses.

---
 rtl/ifu_fetch.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: sequential PC generation, req/gnt word fetch and an in-order instruction FIFO.
// Optional IFU_BUSERR_EN adds per-entry bus error tracking (i_ibus_err / o_data_err).
`ifndef XLEN_DEF
`define XLEN_DEF [31:0]
`endif
`ifndef ILEN_DEF
`define ILEN_DEF [31:0]
`endif

module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic           i_clk,
   input  logic           i_rstn,
   input  logic           i_stop,
   input  logic           i_flush,
   input  logic `XLEN_DEF i_flush_addr,
   input  logic           i_bpu_taken,
   input  logic `XLEN_DEF i_bpu_jaddr,
   output logic           o_ibus_req,
   output logic `XLEN_DEF o_ibus_addr,
   input  logic           i_ibus_gnt,
   input  logic           i_ibus_rvld,
   input  logic `ILEN_DEF i_ibus_rdata,
`ifdef IFU_BUSERR_EN
   input  logic           i_ibus_err,
   output logic           o_data_err,
`endif
   output logic           o_data_vld,
   output logic `XLEN_DEF o_iaddr,
   output logic `ILEN_DEF o_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]   pc;
   logic [31:0]   rsp_pc;
   logic [CW-1:0] cnt_inflight;
   logic [CW-1:0] cnt_drop;
   logic [CW-1:0] wr_ptr;
   logic [CW-1:0] rd_ptr;
   logic [CW-1:0] fifo_cnt;
   logic [CW-1:0] live;
   logic [CW:0]   used;
   logic [31:0]   target;
   logic [31:0]   mem_pc   [DEPTH];
   logic [31:0]   mem_data [DEPTH];
   logic          redir;
   logic          credit_ok;
   logic          grant;
   logic          rsp;
   logic          drop;
   logic          push;
   logic          pop;

   assign fifo_cnt   = wr_ptr - rd_ptr;
   assign o_data_vld = (fifo_cnt != '0) & ~i_flush;
   assign pop        = o_data_vld & ~i_stop;

   // A taken prediction only counts when the next stage actually accepts the head.
   assign redir  = i_flush | (i_bpu_taken & o_data_vld & ~i_stop);
   assign target = (i_flush ? i_flush_addr : i_bpu_jaddr) & ~32'h0000_0003;

   // Credit: every outstanding useful response must find a free FIFO slot.
   assign live      = cnt_inflight - cnt_drop;
   assign used      = {1'b0, live} + {1'b0, fifo_cnt};
   assign credit_ok = used < (CW+1)'(DEPTH);

   assign o_ibus_req  = i_rstn & ~redir & credit_ok;
   assign o_ibus_addr = pc;
   assign grant       = o_ibus_req & i_ibus_gnt;

   // Responses with nothing outstanding are a bus protocol error and are ignored.
   assign rsp  = i_ibus_rvld & (cnt_inflight != '0);
   assign drop = rsp & (cnt_drop != '0);
   assign push = rsp & ~drop & ~redir;

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         pc           <= RESET_PC;
         rsp_pc       <= RESET_PC;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         cnt_inflight <= '0;
         cnt_drop     <= '0;
      end else begin
         cnt_inflight <= cnt_inflight + CW'(grant) - CW'(rsp);
         if (redir) begin
            pc       <= target;
            rsp_pc   <= target;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt_drop <= cnt_inflight - CW'(rsp);
         end else begin
            if (grant) pc <= pc + 32'd4;
            if (drop)  cnt_drop <= cnt_drop - CW'(1);
            if (push) begin
               rsp_pc <= rsp_pc + 32'd4;
               wr_ptr <= wr_ptr + CW'(1);
            end
            if (pop)   rd_ptr <= rd_ptr + CW'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_pc[wr_ptr[PW-1:0]]   <= rsp_pc;
         mem_data[wr_ptr[PW-1:0]] <= i_ibus_rdata;
      end
   end

   assign o_iaddr = mem_pc[rd_ptr[PW-1:0]];

`ifdef IFU_BUSERR_EN
   logic mem_err [DEPTH];

   always_ff @(posedge i_clk) begin
      if (push) mem_err[wr_ptr[PW-1:0]] <= i_ibus_err;
   end

   // A faulted fetch is handed on as a nop so decode never sees garbage.
   assign o_data_err = mem_err[rd_ptr[PW-1:0]];
   assign o_data     = o_data_err ? 32'h0000_0013 : mem_data[rd_ptr[PW-1:0]];
`else
   assign o_data = mem_data[rd_ptr[PW-1:0]];
`endif

endmodule
